// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared types and constants for the CPU memory bus decoder
package soc_bus_pkg;

    localparam int unsigned MAX_NUM_DEV = 8;
    localparam int unsigned MAX_TIMEOUT = 65535;

    // Read data returned when a selected device never answers.
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bus_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_region_match.sv
// rtl/addr_region_match.sv - priority encoder picking the lowest-index region that claims an address
module addr_region_match
    import soc_bus_pkg::*;
#(
    parameter int unsigned               NUM_DEV  = 4,
    parameter logic [NUM_DEV*32-1:0]     DEV_BASE = {32'h0004_0000, 32'h0003_0000,
                                                     32'h0002_0000, 32'h0001_0000},
    parameter logic [NUM_DEV*32-1:0]     DEV_MASK = {4{32'hFFFF_0000}},
    parameter int unsigned               IDX_W    = idx_width(NUM_DEV)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest matching index is written last and wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
            if ((addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - single-outstanding CPU bus to NUM_DEV device decoder with timeout
module mem_bus_decoder
    import soc_bus_pkg::*;
#(
    parameter int unsigned               NUM_DEV  = 4,
    parameter logic [NUM_DEV*32-1:0]     DEV_BASE = {32'h0004_0000, 32'h0003_0000,
                                                     32'h0002_0000, 32'h0001_0000},
    parameter logic [NUM_DEV*32-1:0]     DEV_MASK = {4{32'hFFFF_0000}},
    parameter int unsigned               TIMEOUT  = 255
) (
    input  logic                    axi_aclk_i,
    input  logic                    axi_aresetn_i,

    input  logic                    mem_valid_i,
    input  logic                    mem_wen_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             mem_wdata_i,
    input  logic [3:0]              mem_strb_i,
    output logic [31:0]             mem_rdata_o,
    output logic                    mem_done_o,
    output logic                    mem_err_o,

    output logic [NUM_DEV-1:0]      dev_valid_o,
    output logic                    dev_wen_o,
    output logic [31:0]             dev_addr_o,
    output logic [31:0]             dev_wdata_o,
    output logic [3:0]              dev_strb_o,
    input  logic [NUM_DEV*32-1:0]   dev_rdata_i,
    input  logic [NUM_DEV-1:0]      dev_done_i
);

    localparam int unsigned      IDX_W     = idx_width(NUM_DEV);
    localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    if (NUM_DEV == 0 || NUM_DEV > MAX_NUM_DEV) begin : g_bad_num_dev
        $error("mem_bus_decoder: NUM_DEV must be 1..%0d", MAX_NUM_DEV);
    end
    if (TIMEOUT == 0 || TIMEOUT > MAX_TIMEOUT) begin : g_bad_timeout
        $error("mem_bus_decoder: TIMEOUT must be 1..%0d", MAX_TIMEOUT);
    end

    bus_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [31:0]            resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;
    logic [NUM_DEV-1:0]     dev_valid_d;
    logic                   done_d;
    logic                   load_req;

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   sel_done;
    logic [31:0]            sel_rdata;

    addr_region_match #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK),
        .IDX_W    (IDX_W)
    ) u_match (
        .addr (mem_addr_i),
        .hit  (hit),
        .idx  (hit_idx)
    );

    // Only the selected device's completion and data are ever looked at.
    always_comb begin
        sel_done  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_done  = dev_done_i[i];
                sel_rdata = dev_rdata_i[i*32 +: 32];
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        dev_valid_d = '0;
        done_d      = 1'b0;
        load_req    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    load_req = 1'b1;
                    if (hit) begin
                        state_d = ISSUE;
                        sel_d   = hit_idx;
                        for (int i = 0; i < int'(NUM_DEV); i++) begin
                            dev_valid_d[i] = (hit_idx == IDX_W'(i));
                        end
                    end else begin
                        state_d     = RESP;
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end
                end
            end

            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end

            // A completion in the expiry cycle still counts as a normal answer.
            WAIT: begin
                if (sel_done) begin
                    state_d     = RESP;
                    resp_data_d = dev_wen_o ? 32'h0 : sel_rdata;
                    resp_err_d  = 1'b0;
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_d     = RESP;
                    resp_data_d = ERR_RDATA;
                    resp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RESP: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            dev_valid_o <= '0;
            dev_wen_o   <= 1'b0;
            dev_addr_o  <= '0;
            dev_wdata_o <= '0;
            dev_strb_o  <= '0;
            mem_done_o  <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            dev_valid_o <= dev_valid_d;
            mem_done_o  <= done_d;
            if (load_req) begin
                dev_wen_o   <= mem_wen_i;
                dev_addr_o  <= mem_addr_i;
                dev_wdata_o <= mem_wdata_i;
                dev_strb_o  <= mem_strb_i;
            end
            if (done_d) begin
                mem_rdata_o <= resp_data_q;
                mem_err_o   <= resp_err_q;
            end
        end
    end

endmodule
